// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//
// Opcode-driven microcode sequencer. A programmable dispatch table maps the
// opcode to a microcode start address. The sequencer then walks a
// programmable microcode store one word per enabled clock and presents each
// word's control bits to the datapath. A step watchdog stops runaway
// microprograms by raising a sticky fault and forcing the finish line.
//
// Ports
//   clock                            system clock, rising-edge active
//   reset_n                          asynchronous active-low reset
//   opcode                           opcode of the current instruction
//   microcode_sequencer_load_n       active-low load of the start address
//   microcode_sequencer_enable       advance one microstep per clock
//   microcode_rom_read_enable        gates control_word and finish outputs
//   prog_we / prog_sel               programming strobe; 0 = dispatch, 1 = store
//   prog_addr / prog_data            programming address and data
//   control_word                     control bits of the current microword
//   instruction_finish_control_line  last microword reached, or fault
//   uaddr                            current microcode address (debug)
//   fault                            sticky watchdog / address-overflow flag
module microcode_sequencer #(
  parameter int OPCODE_WIDTH  = 4,
  parameter int UADDR_WIDTH   = 6,
  parameter int CONTROL_WIDTH = 16,
  parameter int MAX_STEPS     = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [OPCODE_WIDTH-1:0]  opcode,
  input  logic                     microcode_sequencer_load_n,
  input  logic                     microcode_sequencer_enable,
  input  logic                     microcode_rom_read_enable,
  input  logic                     prog_we,
  input  logic                     prog_sel,
  input  logic [UADDR_WIDTH-1:0]   prog_addr,
  input  logic [CONTROL_WIDTH:0]   prog_data,
  output logic [CONTROL_WIDTH-1:0] control_word,
  output logic                     instruction_finish_control_line,
  output logic [UADDR_WIDTH-1:0]   uaddr,
  output logic                     fault
);

  localparam int DISP_DEPTH  = 2 ** OPCODE_WIDTH;
  localparam int STORE_DEPTH = 2 ** UADDR_WIDTH;
  localparam int STEP_W      = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0]      STEP_LAST  = STEP_W'(MAX_STEPS - 1);
  localparam logic [UADDR_WIDTH-1:0] UADDR_LAST = '1;

  // Programmable tables; contents survive reset.
  logic [UADDR_WIDTH-1:0] dispatch_mem [DISP_DEPTH];
  logic [CONTROL_WIDTH:0] store_mem    [STORE_DEPTH];

  logic [UADDR_WIDTH-1:0] uaddr_q, uaddr_d;
  logic [CONTROL_WIDTH:0] word_q,  word_d;
  logic [STEP_W-1:0]      step_q,  step_d;
  logic                   fault_q, fault_d;

  logic                   load;
  logic                   prog_wr;
  logic                   parked;
  logic                   at_limit;
  logic [UADDR_WIDTH-1:0] load_addr;
  logic [UADDR_WIDTH-1:0] uaddr_inc;

  assign load    = ~microcode_sequencer_load_n;
  // Writes are only accepted while the sequencer is idle, so a table read
  // for load/step never races with a write to the same entry.
  assign prog_wr = prog_we & microcode_sequencer_load_n & ~microcode_sequencer_enable;

  always_ff @(posedge clock) begin
    if (prog_wr) begin
      if (!prog_sel) begin
        dispatch_mem[prog_addr[OPCODE_WIDTH-1:0]] <= prog_data[UADDR_WIDTH-1:0];
      end else begin
        store_mem[prog_addr] <= prog_data;
      end
    end
  end

  assign load_addr = dispatch_mem[opcode];
  assign uaddr_inc = uaddr_q + UADDR_WIDTH'(1);
  // A word with the end bit, or a latched fault, parks the sequencer.
  assign parked    = word_q[CONTROL_WIDTH] | fault_q;
  // Either limit stops stepping: no wrap past the top of the store, and no
  // more than MAX_STEPS words per instruction.
  assign at_limit  = (uaddr_q == UADDR_LAST) || (step_q == STEP_LAST);

  always_comb begin
    uaddr_d = uaddr_q;
    word_d  = word_q;
    step_d  = step_q;
    fault_d = fault_q;
    if (load) begin
      uaddr_d = load_addr;
      word_d  = store_mem[load_addr];
      step_d  = '0;
      fault_d = 1'b0;
    end else if (microcode_sequencer_enable && !parked) begin
      if (at_limit) begin
        fault_d = 1'b1;
        word_d  = '0;
      end else begin
        uaddr_d = uaddr_inc;
        word_d  = store_mem[uaddr_inc];
        step_d  = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uaddr_q <= '0;
      word_q  <= '0;
      step_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      uaddr_q <= uaddr_d;
      word_q  <= word_d;
      step_q  <= step_d;
      fault_q <= fault_d;
    end
  end

  // Outputs are decoded from registers only; opcode/enable have no
  // combinational path to them.
  assign control_word = microcode_rom_read_enable ? word_q[CONTROL_WIDTH-1:0]
                                                  : '0;
  assign instruction_finish_control_line =
      microcode_rom_read_enable & (word_q[CONTROL_WIDTH] | fault_q);
  assign uaddr = uaddr_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

  logic        clock;
  logic        reset_n;
  logic [3:0]  opcode;
  logic        load_n;
  logic        enable;
  logic        rom_rd;
  logic        prog_we;
  logic        prog_sel;
  logic [5:0]  prog_addr;
  logic [16:0] prog_data;
  logic [15:0] control_word;
  logic        finish;
  logic [5:0]  uaddr;
  logic        fault;

  microcode_sequencer #(
    .OPCODE_WIDTH (4),
    .UADDR_WIDTH  (6),
    .CONTROL_WIDTH(16),
    .MAX_STEPS    (32)
  ) dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .opcode                         (opcode),
    .microcode_sequencer_load_n     (load_n),
    .microcode_sequencer_enable     (enable),
    .microcode_rom_read_enable      (rom_rd),
    .prog_we                        (prog_we),
    .prog_sel                       (prog_sel),
    .prog_addr                      (prog_addr),
    .prog_data                      (prog_data),
    .control_word                   (control_word),
    .instruction_finish_control_line(finish),
    .uaddr                          (uaddr),
    .fault                          (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [15:0] cw;
    logic        fin;
    logic [5:0]  ua;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   nchecks = 0;
  int   nerr    = 0;
  event chk_now;

  task automatic push_exp(input string n, input logic [15:0] cw, input logic fin,
                          input logic [5:0] ua, input logic flt);
    exp_t e;
    e.name = n;
    e.cw   = cw;
    e.fin  = fin;
    e.ua   = ua;
    e.flt  = flt;
    sb.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge (or after an
  // explicit mid-cycle trigger) and checks every pending expectation.
  initial begin
    forever begin
      @(posedge clock or chk_now);
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        nchecks++;
        if ({control_word, finish, uaddr, fault} !== {e.cw, e.fin, e.ua, e.flt}) begin
          nerr++;
          $display("FAIL %s: got cw=%h fin=%b ua=%0d flt=%b, expected cw=%h fin=%b ua=%0d flt=%b",
                   e.name, control_word, finish, uaddr, fault, e.cw, e.fin, e.ua, e.flt);
        end
      end
    end
  end

  task automatic drive(input logic ld_n, input logic en, input logic rd, input logic [3:0] op);
    @(negedge clock);
    load_n  = ld_n;
    enable  = en;
    rom_rd  = rd;
    opcode  = op;
    prog_we = 1'b0;
    @(posedge clock);
  endtask

  task automatic prog(input logic sel, input logic [5:0] addr, input logic [16:0] data);
    @(negedge clock);
    load_n    = 1'b1;
    enable    = 1'b0;
    prog_we   = 1'b1;
    prog_sel  = sel;
    prog_addr = addr;
    prog_data = data;
    @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    opcode    = '0;
    load_n    = 1'b1;
    enable    = 1'b0;
    rom_rd    = 1'b1;
    prog_we   = 1'b0;
    prog_sel  = 1'b0;
    prog_addr = '0;
    prog_data = '0;

    repeat (2) @(posedge clock);
    push_exp("reset", 16'h0000, 1'b0, 6'd0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single-word microprogram
    prog(1'b0, 6'd3, 17'd10);
    prog(1'b1, 6'd10, 17'h100A5);
    drive(1'b0, 1'b0, 1'b1, 4'd3); push_exp("t1_load",   16'h00A5, 1'b1, 6'd10, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd3); push_exp("t1_hold_a", 16'h00A5, 1'b1, 6'd10, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd3); push_exp("t1_hold_b", 16'h00A5, 1'b1, 6'd10, 1'b0);

    // Three-word microprogram
    prog(1'b0, 6'd5, 17'd20);
    prog(1'b1, 6'd20, 17'h00001);
    prog(1'b1, 6'd21, 17'h00002);
    prog(1'b1, 6'd22, 17'h10004);
    drive(1'b0, 1'b0, 1'b1, 4'd5); push_exp("t2_w0",   16'h0001, 1'b0, 6'd20, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd5); push_exp("t2_w1",   16'h0002, 1'b0, 6'd21, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd5); push_exp("t2_w2",   16'h0004, 1'b1, 6'd22, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd5); push_exp("t2_park", 16'h0004, 1'b1, 6'd22, 1'b0);

    // Load beats enable; read-enable gating
    drive(1'b0, 1'b0, 1'b1, 4'd3); push_exp("t3_pre",        16'h00A5, 1'b1, 6'd10, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 4'd5); push_exp("t3_ld_en",      16'h0001, 1'b0, 6'd20, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd5); push_exp("t3_rd_off",     16'h0000, 1'b0, 6'd20, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'd3); push_exp("t3_rd_off_end", 16'h0000, 1'b0, 6'd10, 1'b0);

    // Step watchdog: 40 words without end bit starting at 0
    for (int i = 0; i < 40; i++) prog(1'b1, 6'(i), {1'b0, 16'h0100 + 16'(i)});
    prog(1'b0, 6'd0, 17'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd0); push_exp("t4_load", 16'h0100, 1'b0, 6'd0, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      drive(1'b1, 1'b1, 1'b1, 4'd0);
      push_exp($sformatf("t4_step%0d", k), 16'h0100 + 16'(k), 1'b0, 6'(k), 1'b0);
    end
    drive(1'b1, 1'b1, 1'b1, 4'd0); push_exp("t4_fault",       16'h0000, 1'b1, 6'd31, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 4'd0); push_exp("t4_fault_hold",  16'h0000, 1'b1, 6'd31, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'd0); push_exp("t4_fault_rdoff", 16'h0000, 1'b0, 6'd31, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 4'd0); push_exp("t4_reload",      16'h0100, 1'b0, 6'd0,  1'b0);

    // Address overflow: no wrap from 63 to 0
    prog(1'b1, 6'd62, 17'h03E00);
    prog(1'b1, 6'd63, 17'h03F00);
    prog(1'b0, 6'd7, 17'd62);
    drive(1'b0, 1'b0, 1'b1, 4'd7); push_exp("t5_load",   16'h3E00, 1'b0, 6'd62, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd7); push_exp("t5_63",     16'h3F00, 1'b0, 6'd63, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd7); push_exp("t5_fault",  16'h0000, 1'b1, 6'd63, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 4'd7); push_exp("t5_nowrap", 16'h0000, 1'b1, 6'd63, 1'b1);

    // Writes dropped while enable or load is active
    @(negedge clock);
    load_n = 1'b1; enable = 1'b1; rom_rd = 1'b1;
    prog_we = 1'b1; prog_sel = 1'b1; prog_addr = 6'd62; prog_data = 17'h15555;
    @(posedge clock); push_exp("t6_we_en", 16'h0000, 1'b1, 6'd63, 1'b1);
    @(negedge clock);
    load_n = 1'b0; enable = 1'b0; opcode = 4'd7;
    prog_we = 1'b1; prog_sel = 1'b0; prog_addr = 6'd7; prog_data = 17'd5;
    @(posedge clock); push_exp("t6_load", 16'h3E00, 1'b0, 6'd62, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'd7); push_exp("t6_disp_kept", 16'h3E00, 1'b0, 6'd62, 1'b0);

    // Asynchronous reset mid-instruction; programmed contents survive
    drive(1'b0, 1'b0, 1'b1, 4'd5); push_exp("t7_load", 16'h0114, 1'b0, 6'd20, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd5); push_exp("t7_step", 16'h0115, 1'b0, 6'd21, 1'b0);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    push_exp("t7_rst_async", 16'h0000, 1'b0, 6'd0, 1'b0);
    -> chk_now;
    @(posedge clock); push_exp("t7_rst_hold", 16'h0000, 1'b0, 6'd0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1; load_n = 1'b1; enable = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 4'd7); push_exp("t7_after_rst",  16'h3E00, 1'b0, 6'd62, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd7); push_exp("t7_after_step", 16'h3F00, 1'b0, 6'd63, 1'b0);

    @(negedge clock);
    @(negedge clock);
    nchecks++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
